// File: rtl/router_output_port_allocator.sv
// router_output_port_allocator
//   Switch/VC allocator for a single router output port. It picks one of the
//   NUM_IN requesting inputs using a round-robin search, then holds the port
//   for that input until the packet's tail flit has gone out (wormhole). It
//   also keeps one downstream credit counter per VC: a flit is sent only if
//   its VC has a credit left.
//
//   Optional feature: define ROUTER_ALLOC_STATS_EN to add the stat_flits and
//   stat_stall counters. The default build leaves the macro undefined.
//
// Ports
//   clk, reset     clock and synchronous active-high reset
//   req            per-input request for this output
//   req_vc         per-input target VC, slice [i*VC_W +: VC_W]
//   req_head       per-input head-flit marker
//   req_tail       per-input tail-flit marker
//   credit_in      credit return: [VC_W] = valid, [VC_W-1:0] = vc
//   gnt            one-hot grant (combinational)
//   gnt_vc         VC of the granted flit, 0 when nothing is granted
//   credit_avail   bit v set when VC v has at least one credit
//   locked         port owned by a packet in flight
//   error          sticky flag, set when a credit returns to a full VC
//   stat_flits     (stats build only) count of flits sent
//   stat_stall     (stats build only) count of cycles stalled for lack of credit
module router_output_port_allocator #(
    parameter int NUM_IN    = 5,
    parameter int NUM_VC    = 4,
    parameter int BUF_DEPTH = 8,
    localparam int VC_W     = $clog2(NUM_VC),
    localparam int IW       = $clog2(NUM_IN),
    localparam int CW       = $clog2(BUF_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_IN-1:0]      req,
    input  logic [NUM_IN*VC_W-1:0] req_vc,
    input  logic [NUM_IN-1:0]      req_head,
    input  logic [NUM_IN-1:0]      req_tail,
    input  logic [VC_W:0]          credit_in,
    output logic [NUM_IN-1:0]      gnt,
    output logic [VC_W-1:0]        gnt_vc,
    output logic [NUM_VC-1:0]      credit_avail,
    output logic                   locked,
`ifdef ROUTER_ALLOC_STATS_EN
    output logic [31:0]            stat_flits,
    output logic [31:0]            stat_stall,
`endif
    output logic                   error
);

    typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [VC_W-1:0] owner_vc_q, owner_vc_d;
    logic [CW-1:0]   credit_q [NUM_VC];
    logic [CW-1:0]   credit_d [NUM_VC];
    logic            error_q, error_d;

    logic [NUM_IN-1:0] gnt_s;
    logic [VC_W-1:0]   gnt_vc_s;
    logic [IW-1:0]     gnt_idx_s;
    logic              fire_s;

    // State register: FSM state, arbitration pointer, ownership, credits, error
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            owner_vc_q <= '0;
            error_q    <= 1'b0;
            for (int v = 0; v < NUM_VC; v++) credit_q[v] <= CW'(BUF_DEPTH);
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            owner_vc_q <= owner_vc_d;
            error_q    <= error_d;
            for (int v = 0; v < NUM_VC; v++) credit_q[v] <= credit_d[v];
        end
    end

    // Grant logic: round-robin search over head flits in IDLE, owner only in LOCKED
    always_comb begin
        logic [IW:0]     sum;
        logic [IW-1:0]   idx;
        logic [VC_W-1:0] vc;
        logic            found;
        gnt_s     = '0;
        gnt_vc_s  = '0;
        gnt_idx_s = '0;
        sum       = '0;
        idx       = '0;
        vc        = '0;
        found     = 1'b0;
        if (reset) begin
            gnt_s = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    for (int k = 0; k < NUM_IN; k++) begin
                        // Wrap the search index without a modulo operator.
                        sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
                        if (sum >= (IW+1)'(NUM_IN)) sum = sum - (IW+1)'(NUM_IN);
                        else sum = sum;
                        idx = sum[IW-1:0];
                        vc  = req_vc[int'(idx)*VC_W +: VC_W];
                        if (!found && req[idx] && req_head[idx] && (credit_q[vc] != '0)) begin
                            found     = 1'b1;
                            gnt_idx_s = idx;
                            gnt_vc_s  = vc;
                            gnt_s     = NUM_IN'(1) << idx;
                        end else begin
                            found = found;
                        end
                    end
                end
                LOCKED: begin
                    // The VC was fixed when the head flit went out.
                    if (req[owner_q] && (credit_q[owner_vc_q] != '0)) begin
                        gnt_idx_s = owner_q;
                        gnt_vc_s  = owner_vc_q;
                        gnt_s     = NUM_IN'(1) << owner_q;
                    end else begin
                        gnt_s = '0;
                    end
                end
                default: gnt_s = '0;
            endcase
        end
    end

    assign fire_s = |gnt_s;

    // Next-state logic: wormhole lock/unlock, pointer advance, credit accounting
    always_comb begin
        logic cons;
        logic ret;
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        owner_vc_d = owner_vc_q;
        error_d    = error_q;
        cons       = 1'b0;
        ret        = 1'b0;
        case (state_q)
            IDLE: begin
                if (fire_s) begin
                    rr_ptr_d = (gnt_idx_s == IW'(NUM_IN - 1)) ? '0 : gnt_idx_s + IW'(1);
                    if (!req_tail[gnt_idx_s]) begin
                        state_d    = LOCKED;
                        owner_d    = gnt_idx_s;
                        owner_vc_d = gnt_vc_s;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                if (fire_s && req_tail[owner_q]) state_d = IDLE;
                else state_d = LOCKED;
            end
            default: state_d = IDLE;
        endcase
        for (int v = 0; v < NUM_VC; v++) begin
            cons = fire_s && (gnt_vc_s == VC_W'(v));
            ret  = credit_in[VC_W] && (credit_in[VC_W-1:0] == VC_W'(v));
            if (cons && ret) begin
                credit_d[v] = credit_q[v];
            end else if (cons) begin
                credit_d[v] = credit_q[v] - CW'(1);
            end else if (ret) begin
                // A return to a full VC means upstream/downstream disagree.
                if (credit_q[v] == CW'(BUF_DEPTH)) begin
                    credit_d[v] = credit_q[v];
                    error_d     = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + CW'(1);
                end
            end else begin
                credit_d[v] = credit_q[v];
            end
        end
    end

    // Output logic: status flags derived from registered state
    always_comb begin
        gnt    = gnt_s;
        gnt_vc = gnt_vc_s;
        locked = (state_q == LOCKED);
        error  = error_q;
        for (int v = 0; v < NUM_VC; v++) credit_avail[v] = (credit_q[v] != '0);
    end

`ifdef ROUTER_ALLOC_STATS_EN
    logic [31:0] stat_flits_q;
    logic [31:0] stat_stall_q;
    logic        stall_s;

    // Stall detection: a request exists but credit is the only blocker
    always_comb begin
        logic any_credit;
        any_credit = 1'b0;
        stall_s    = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (req[i] && (credit_q[req_vc[i*VC_W +: VC_W]] != '0)) any_credit = 1'b1;
            else any_credit = any_credit;
        end
        if (reset) begin
            stall_s = 1'b0;
        end else if (state_q == LOCKED) begin
            stall_s = req[owner_q] && (credit_q[owner_vc_q] == '0);
        end else begin
            stall_s = (|req) && !any_credit;
        end
    end

    // Statistics counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_flits_q <= 32'd0;
            stat_stall_q <= 32'd0;
        end else begin
            stat_flits_q <= stat_flits_q + (fire_s ? 32'd1 : 32'd0);
            stat_stall_q <= stat_stall_q + (stall_s ? 32'd1 : 32'd0);
        end
    end

    assign stat_flits = stat_flits_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_router_output_port_allocator.sv
// Directed testbench for router_output_port_allocator: reset state, single-flit
// grant, round-robin rotation and credit exhaustion, wormhole locking, credit
// stall and re-grant, credit overflow error, same-cycle consume/return, and
// reset in the middle of a packet.
module tb_router_output_port_allocator;

    logic       clk;
    logic       reset;
    logic [4:0] req;
    logic [9:0] req_vc;
    logic [4:0] req_head;
    logic [4:0] req_tail;
    logic [2:0] credit_in;
    logic [4:0] gnt;
    logic [1:0] gnt_vc;
    logic [3:0] credit_avail;
    logic       locked;
    logic       error;
`ifdef ROUTER_ALLOC_STATS_EN
    logic [31:0] stat_flits;
    logic [31:0] stat_stall;
`endif

    int total_cnt;
    int pass_cnt;

    router_output_port_allocator dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_vc       (req_vc),
        .req_head     (req_head),
        .req_tail     (req_tail),
        .credit_in    (credit_in),
        .gnt          (gnt),
        .gnt_vc       (gnt_vc),
        .credit_avail (credit_avail),
        .locked       (locked),
`ifdef ROUTER_ALLOC_STATS_EN
        .stat_flits   (stat_flits),
        .stat_stall   (stat_stall),
`endif
        .error        (error)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock and settle past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req       = 5'b00000;
        req_vc    = 10'd0;
        req_head  = 5'b00000;
        req_tail  = 5'b00000;
        credit_in = 3'b000;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        idle_inputs();
        reset = 1'b1;
        // Request during reset must not be granted
        req = 5'b00001; req_head = 5'b00001; req_tail = 5'b00001;
        step();
        step();
        check_eq("rst_gnt", 32'(gnt), 32'h0);
        check_eq("rst_locked", 32'(locked), 32'h0);
        check_eq("rst_error", 32'(error), 32'h0);
        check_eq("rst_avail", 32'(credit_avail), 32'hF);
        idle_inputs();
        reset = 1'b0;
        #1;

        // Test 1: single-flit packet from input 0 on vc2
        req = 5'b00001; req_head = 5'b00001; req_tail = 5'b00001; req_vc = 10'd2;
        #1;
        check_eq("t1_gnt", 32'(gnt), 32'h01);
        check_eq("t1_gnt_vc", 32'(gnt_vc), 32'h2);
        step();
        check_eq("t1_locked", 32'(locked), 32'h0);
        // rr_ptr is now 1: input 1 wins over input 0
        req = 5'b00011; req_head = 5'b00011; req_tail = 5'b00011; req_vc = 10'd0;
        #1;
        check_eq("t1_rr", 32'(gnt), 32'h02);
        step();
        idle_inputs();
        // credit[2] is 7: one return fills it, a second overflows
        credit_in = 3'b110;
        step();
        check_eq("t5_noerr", 32'(error), 32'h0);
        step();
        credit_in = 3'b000;
        #1;
        check_eq("t5_err", 32'(error), 32'h1);
        check_eq("t5_avail", 32'(credit_avail), 32'hF);
        step();
        step();
        check_eq("t5_sticky", 32'(error), 32'h1);
        do_reset();
        check_eq("t5_clr", 32'(error), 32'h0);

        // Test 2: all five inputs, single flits on vc0
        req = 5'b11111; req_head = 5'b11111; req_tail = 5'b11111; req_vc = 10'd0;
        #1;
        for (int n = 0; n < 8; n++) begin
            logic [4:0] exp_g;
            exp_g = 5'b00001 << (n % 5);
            check_eq($sformatf("t2_rot%0d", n), 32'(gnt), 32'(exp_g));
            step();
        end
        check_eq("t2_gnt0", 32'(gnt), 32'h0);
        check_eq("t2_avail", 32'(credit_avail), 32'hE);
        // One credit back on vc0: rr_ptr is 3
        credit_in = 3'b100;
        step();
        credit_in = 3'b000;
        #1;
        check_eq("t2_regnt", 32'(gnt), 32'h08);
        do_reset();

        // Test 3: wormhole lock by input 3 on vc1
        req = 5'b01000; req_head = 5'b01000; req_vc = 10'd1 << 6;
        #1;
        check_eq("t3_head", 32'(gnt), 32'h08);
        check_eq("t3_head_vc", 32'(gnt_vc), 32'h1);
        step();
        check_eq("t3_locked", 32'(locked), 32'h1);
        req = 5'b01010; req_head = 5'b00010;
        #1;
        check_eq("t3_body", 32'(gnt), 32'h08);
        step();
        req = 5'b00010;
        #1;
        check_eq("t3_drop", 32'(gnt), 32'h0);
        step();
        check_eq("t3_still_locked", 32'(locked), 32'h1);
        req = 5'b01010; req_tail = 5'b01000;
        #1;
        check_eq("t3_tail", 32'(gnt), 32'h08);
        step();
        check_eq("t3_unlocked", 32'(locked), 32'h0);
        req = 5'b00010; req_tail = 5'b00000;
        #1;
        check_eq("t3_next", 32'(gnt), 32'h02);
        check_eq("t3_next_vc", 32'(gnt_vc), 32'h0);
        do_reset();

        // Test 4: owner on vc1 runs out of credit, then is re-granted
        req = 5'b00001; req_head = 5'b00001; req_vc = 10'd1;
        step();
        req_head = 5'b00000;
        for (int n = 0; n < 6; n++) step();
        check_eq("t4_one_left", 32'(credit_avail), 32'hF);
        step();
        check_eq("t4_stall_gnt", 32'(gnt), 32'h0);
        check_eq("t4_avail", 32'(credit_avail), 32'hD);
        check_eq("t4_locked", 32'(locked), 32'h1);
        credit_in = 3'b101;
        step();
        credit_in = 3'b000;
        #1;
        check_eq("t4_regnt", 32'(gnt), 32'h01);
        check_eq("t4_regnt_vc", 32'(gnt_vc), 32'h1);
        req_tail = 5'b00001;
        step();
        check_eq("t4_unlocked", 32'(locked), 32'h0);
        do_reset();

        // Test 6: same-cycle consume and return on vc2, then mid-packet reset
        req = 5'b00100; req_head = 5'b00100; req_vc = 10'd2 << 4;
        step();
        req_head = 5'b00000;
        credit_in = 3'b110;
        #1;
        check_eq("t6_fire", 32'(gnt), 32'h04);
        step();
        req = 5'b00000;
        // credit[2] should still be 7: one return is fine, the next overflows
        step();
        check_eq("t6_noerr", 32'(error), 32'h0);
        step();
        credit_in = 3'b000;
        #1;
        check_eq("t6_err", 32'(error), 32'h1);
        req = 5'b00100;
        // Use vc2 credits so the reload is observable
        for (int n = 0; n < 8; n++) step();
        check_eq("t6_empty", 32'(credit_avail), 32'hB);
        check_eq("t6_prelock", 32'(locked), 32'h1);
        reset = 1'b1;
        #1;
        check_eq("t6_rst_gnt", 32'(gnt), 32'h0);
        step();
        reset = 1'b0;
        idle_inputs();
        #1;
        check_eq("t6_rst_locked", 32'(locked), 32'h0);
        check_eq("t6_rst_avail", 32'(credit_avail), 32'hF);
        check_eq("t6_rst_err", 32'(error), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
